mips_muldiv_unit: RTL

Iterative multiply/divide unit owning the HI/LO register pair for the MIPS core. It executes MULT, MULTU, DIV and DIVU over a parametrised word width and serves MTHI/MTLO writes and MFHI/MFLO reads. The data path launches an operation with a one-cycle `start` pulse and stalls the pipeline on `busy`. It sits beside the ALU and is controlled by the control unit's decoded `op` field.

---
 rtl/mips_muldiv_unit.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_unit
// Brief    : Iterative radix-2 MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Revision : 1.0
// ============================================================================
module mips_muldiv_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_val,
    input  logic [XLEN-1:0] rt_val,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] wdata,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     opb;
    logic                is_div;
    logic                neg_res;
    logic                neg_rem;
    logic                div0;

    logic                rs_neg;
    logic                rt_neg;
    logic [XLEN-1:0]     rs_mag;
    logic [XLEN-1:0]     rt_mag;
    logic [XLEN:0]       mul_sum;
    logic [XLEN:0]       div_shift;
    logic [XLEN:0]       div_diff;
    logic [2*XLEN-1:0]   acc_step;
    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     fix_hi;
    logic [XLEN-1:0]     fix_lo;

    // Unsigned ops (op[0]=1) never treat the top bit as a sign.
    assign rs_neg = ~op[0] & rs_val[XLEN-1];
    assign rt_neg = ~op[0] & rt_val[XLEN-1];
    assign rs_mag = rs_neg ? (~rs_val + 1'b1) : rs_val;
    assign rt_mag = rt_neg ? (~rt_val + 1'b1) : rt_val;

    // Multiply: acc = {partial product, remaining multiplier bits}.
    assign mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb} : '0);

    // Divide: acc = {remainder, dividend/quotient shift register}.
    assign div_shift = acc[2*XLEN-1:XLEN-1];
    assign div_diff  = div_shift - {1'b0, opb};

    always_comb begin
        acc_step = {mul_sum, acc[XLEN-1:1]};
        if (is_div) begin
            if (!div_diff[XLEN])
                acc_step = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
            else
                acc_step = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    assign prod_fix = neg_res ? (~acc + 1'b1) : acc;
    assign quo      = acc[XLEN-1:0];
    assign rem      = acc[2*XLEN-1:XLEN];

    // A zero divisor yields all-ones quotient and |dividend| remainder; the
    // remainder sign fix restores the raw dividend, the quotient is forced.
    always_comb begin
        fix_hi = prod_fix[2*XLEN-1:XLEN];
        fix_lo = prod_fix[XLEN-1:0];
        if (is_div) begin
            fix_hi = neg_rem ? (~rem + 1'b1) : rem;
            if (div0)
                fix_lo = '1;
            else
                fix_lo = neg_res ? (~quo + 1'b1) : quo;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opb     <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            div0    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (hi_we) hi <= wdata;
                    if (lo_we) lo <= wdata;
                    if (start) begin
                        state   <= RUN;
                        cnt     <= '0;
                        acc     <= {{XLEN{1'b0}}, rs_mag};
                        opb     <= rt_mag;
                        is_div  <= op[1];
                        neg_res <= rs_neg ^ rt_neg;
                        neg_rem <= rs_neg;
                        div0    <= op[1] & (rt_val == '0);
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    acc <= acc_step;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(XLEN-1))
                        state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
